// File: rtl/frame_sender.sv
// rtl/frame_sender.sv - Ethernet delay-test frame generator driving the MAC TX client byte port.
// Each frame carries a sequence number and the ts_cnt value latched at first-byte ack.
module frame_sender #(
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h000A35000001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          FRAME_LEN = 64,
  parameter int          IFG       = 12
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] seq,
  output logic [31:0] tx_ts,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        mac_tx_underrun
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, DATA, GAP} state_t;

  localparam logic [13:0] LAST_IDX = 14'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_INIT = 8'(IFG - 1);

  state_t       state_q, state_d;
  logic [13:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]  ts_cnt_q, ts_cnt_d;
  logic [31:0]  seq_q, seq_d;
  logic [31:0]  tx_ts_q, tx_ts_d;
  logic [7:0]   data_q, data_d;
  logic         dvld_q, dvld_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [175:0] hdr;
  logic [13:0]  nxt_idx;
  logic [7:0]   nxt_byte;
  logic         last_byte;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ts_cnt_q   <= '0;
      seq_q      <= '0;
      tx_ts_q    <= '0;
      data_q     <= '0;
      dvld_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ts_cnt_q   <= ts_cnt_d;
      seq_q      <= seq_d;
      tx_ts_q    <= tx_ts_d;
      data_q     <= data_d;
      dvld_q     <= dvld_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = WAIT_ACK;
      WAIT_ACK: if (mac_tx_ack) state_d = DATA;
      DATA:     if (last_byte) state_d = GAP;
      GAP:      if (gap_cnt_q == 8'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Header bytes 0..21 in wire order; beyond that the pad byte is the low index bits.
  assign hdr       = {DST_MAC, SRC_MAC, ETHERTYPE, seq_q, tx_ts_q};
  assign nxt_idx   = byte_cnt_q + 14'd1;
  assign last_byte = (byte_cnt_q == LAST_IDX);

  always_comb begin
    if (nxt_idx < 14'd22) nxt_byte = hdr[8'd175 - {nxt_idx[4:0], 3'b000} -: 8];
    else                  nxt_byte = nxt_idx[7:0];
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    tx_ts_d    = tx_ts_q;
    data_d     = 8'd0;
    dvld_d     = 1'b0;
    done_d     = 1'b0;
    ts_cnt_d   = ts_cnt_q + 32'd1;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          dvld_d     = 1'b1;
          data_d     = DST_MAC[47:40];
          byte_cnt_d = 14'd0;
        end
      end
      WAIT_ACK: begin
        dvld_d = 1'b1;
        if (mac_tx_ack) begin
          tx_ts_d    = ts_cnt_q;
          byte_cnt_d = nxt_idx;
          data_d     = nxt_byte;
        end else begin
          data_d = data_q;
        end
      end
      DATA: begin
        if (last_byte) begin
          done_d     = 1'b1;
          seq_d      = seq_q + 32'd1;
          byte_cnt_d = 14'd0;
          gap_cnt_d  = GAP_INIT;
        end else begin
          dvld_d     = 1'b1;
          data_d     = nxt_byte;
          byte_cnt_d = nxt_idx;
        end
      end
      GAP: begin
        if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: ;
    endcase
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign seq             = seq_q;
  assign tx_ts           = tx_ts_q;
  assign mac_tx_data     = data_q;
  assign mac_tx_dvld     = dvld_q;
  assign mac_tx_underrun = 1'b0;
endmodule

// File: tb/tb_frame_sender.sv
// tb/tb_frame_sender.sv - Directed scoreboard bench for frame_sender.
// Expected bytes are queued when the bench acks a frame and popped as the MAC port emits them.
module tb_frame_sender;
  logic        rx_clk = 1'b0;
  logic        reset;
  logic        start, mac_tx_ack, busy, done, mac_tx_dvld, mac_tx_underrun;
  logic [31:0] seq, tx_ts;
  logic [7:0]  mac_tx_data;
  logic        start2, ack2, busy2, done2, dvld2, underrun2;
  logic [31:0] seq2, tx_ts2;
  logic [7:0]  data2;

  int          errors = 0, checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] tb_ts = 0, exp_seq = 0, ack_ts = 0, prev_ack_ts = 0;
  int          ack_delay = 0, wcnt = 0, flen = 0, last_len = 0, done_cnt = 0;
  int          rises = 0, low_cnt = 0, gap_seen = 0;
  bit          frame_open = 0, acked = 0, chk_gap = 0, ack_noise = 0;

  always #5 rx_clk = ~rx_clk;

  frame_sender dut (
    .rx_clk(rx_clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .seq(seq), .tx_ts(tx_ts), .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld),
    .mac_tx_ack(mac_tx_ack), .mac_tx_underrun(mac_tx_underrun)
  );

  frame_sender #(.FRAME_LEN(60), .IFG(1)) dut2 (
    .rx_clk(rx_clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .seq(seq2), .tx_ts(tx_ts2), .mac_tx_data(data2), .mac_tx_dvld(dvld2),
    .mac_tx_ack(ack2), .mac_tx_underrun(underrun2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] s, input logic [31:0] ts);
    logic [7:0] src [6];
    src = '{8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01};
    if (idx < 6)        return 8'hFF;
    else if (idx < 12)  return src[idx-6];
    else if (idx == 12) return 8'h88;
    else if (idx == 13) return 8'hB5;
    else if (idx < 18)  return 8'(s >> (8 * (17 - idx)));
    else if (idx < 22)  return 8'(ts >> (8 * (21 - idx)));
    return 8'(idx);
  endfunction

  // One clock: advance the timestamp model, run the ack responder and the scoreboard for dut.
  task automatic tick();
    @(posedge rx_clk); #1;
    if (reset) tb_ts = 0; else tb_ts = tb_ts + 1;
    if (mac_tx_dvld && !frame_open) begin
      frame_open = 1; acked = 0; wcnt = 0; flen = 0; rises++;
      if (chk_gap) begin chk("ifg_low_cycles", low_cnt, 13); gap_seen++; end
      repeat (ack_delay + 1) exp_q.push_back(8'hFF);
    end
    if (!mac_tx_dvld && frame_open) begin frame_open = 0; last_len = flen; low_cnt = 0; end
    if (!mac_tx_dvld) low_cnt++;
    if (frame_open && !acked && wcnt == ack_delay) begin
      mac_tx_ack = 1; acked = 1; prev_ack_ts = ack_ts; ack_ts = tb_ts;
      if (chk_gap) chk("ts_step", ack_ts - prev_ack_ts, 77);
      for (int i = 1; i < 64; i++) exp_q.push_back(exp_byte(i, exp_seq, ack_ts));
    end else begin
      mac_tx_ack = ack_noise && !(frame_open && !acked);
      if (frame_open && !acked) wcnt++;
    end
    if (mac_tx_dvld) begin
      flen++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_byte", mac_tx_data, exp_q.pop_front());
    end else begin
      chk("idle_data_zero", mac_tx_data, 0);
    end
    if (done) begin done_cnt++; exp_seq++; end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin tick(); n++; end while (!done && n < limit);
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    int base, r0, n, nrise, gap2, g2, done2_cnt;
    logic prev2;
    logic [31:0] ts2_a, ts2_b;
    logic [7:0] f1[$];
    logic [7:0] f2[$];

    reset = 1; start = 0; mac_tx_ack = 0; start2 = 0; ack2 = 0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seq", seq, 0);
    chk("rst_tx_ts", tx_ts, 0);
    chk("rst_dvld", 32'(mac_tx_dvld), 0);
    chk("rst_underrun", 32'(mac_tx_underrun), 0);
    reset = 0;

    // Single frame, ack three cycles after dvld rises.
    ack_delay = 3; start = 1; tick(); start = 0;
    chk("a_busy", 32'(busy), 1);
    wait_done(200);
    chk("a_len", last_len, 67);
    chk("a_seq", seq, 1);
    chk("a_tx_ts", tx_ts, ack_ts);
    chk("a_sb_empty", exp_q.size(), 0);
    tick();
    chk("a_done_pulse", 32'(done), 0);
    chk("a_done_cnt", done_cnt, 1);

    // Ack in the first WAIT_ACK cycle.
    wait_idle(50);
    ack_delay = 0; start = 1; tick(); start = 0;
    wait_done(200);
    chk("b_len", last_len, 64);
    chk("b_seq", seq, 2);

    // start held for three back-to-back frames.
    wait_idle(50);
    base = done_cnt; start = 1; tick(); chk_gap = 1;
    n = 0;
    while (done_cnt < base + 3 && n < 600) begin tick(); n++; end
    start = 0; chk_gap = 0;
    chk("c_dones", done_cnt - base, 3);
    chk("c_seq", seq, 5);
    chk("c_gap_checks", gap_seen, 2);
    chk("c_sb_empty", exp_q.size(), 0);

    // start pulses during DATA and GAP are dropped; stray acks are ignored.
    wait_idle(50);
    ack_noise = 1; base = done_cnt; start = 1; tick(); start = 0; r0 = rises;
    n = 0;
    while (flen < 11 && n < 50) begin tick(); n++; end
    start = 1; tick(); start = 0;
    wait_done(200);
    chk("d_len", last_len, 64);
    repeat (3) tick();
    start = 1; tick(); start = 0;
    chk("d_busy_gap", 32'(busy), 1);
    wait_idle(50);
    repeat (20) tick();
    chk("d_no_extra_frame", rises - r0, 0);
    chk("d_one_done", done_cnt - base, 1);
    ack_noise = 0; mac_tx_ack = 0;

    // Reset mid-frame at byte 30.
    start = 1; tick(); start = 0;
    n = 0;
    while (flen < 31 && n < 60) begin tick(); n++; end
    reset = 1; #1;
    chk("e_dvld_async", 32'(mac_tx_dvld), 0);
    chk("e_data", mac_tx_data, 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_seq", seq, 0);
    chk("e_tx_ts", tx_ts, 0);
    exp_q.delete(); frame_open = 0; acked = 0; exp_seq = 0; mac_tx_ack = 0;
    base = done_cnt;
    repeat (2) tick();
    reset = 0;
    tick();
    chk("e_no_done", done_cnt - base, 0);
    start = 1; tick(); start = 0;
    wait_done(200);
    chk("e_len", last_len, 64);
    chk("e_seq_after", seq, 1);
    chk("e_sb_empty", exp_q.size(), 0);

    // FRAME_LEN=60, IFG=1 instance with start held and ack always high.
    start2 = 1; ack2 = 1;
    prev2 = 0; nrise = 0; gap2 = 0; g2 = -1; done2_cnt = 0; ts2_a = 0; ts2_b = 0;
    n = 0;
    while (!(nrise == 2 && f2.size() == 18) && n < 300) begin
      tick(); n++;
      if (dvld2 && !prev2) begin
        nrise++;
        if (nrise == 1) ts2_a = tb_ts;
        if (nrise == 2) begin g2 = gap2; ts2_b = tb_ts; end
      end
      if (!dvld2 && prev2) gap2 = 0;
      if (!dvld2) gap2++;
      if (dvld2 && nrise == 1) f1.push_back(data2);
      if (dvld2 && nrise == 2) f2.push_back(data2);
      if (done2) done2_cnt++;
      prev2 = dvld2;
    end
    start2 = 0;
    chk("f_len", f1.size(), 60);
    if (f1.size() == 60)
      for (int i = 0; i < 60; i++) chk("f_byte", f1[i], exp_byte(i, 0, ts2_a));
    chk("f_gap_idle", g2, 2);
    chk("f_done_cnt", done2_cnt, 1);
    chk("f_seq", seq2, 1);
    chk("f_busy", 32'(busy2), 1);
    chk("f_underrun", 32'(underrun2), 0);
    chk("f_tx_ts", tx_ts2, ts2_b);
    if (f2.size() == 18) chk("f_seq_bytes", {f2[14], f2[15], f2[16], f2[17]}, 1);
    ack2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_sender.md
Name: frame_sender

Overview:
- Generates fixed-format Ethernet test frames for the delay tester.
- Drives the MAC client transmit byte interface.
- Each frame carries a 32-bit sequence number and a 32-bit transmit timestamp, so the receive-side catcher can measure round-trip delay.
- Sits between the test controller (start/done) and the MAC TX client port. The MAC appends the FCS.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC, transmitted MSB first.
- SRC_MAC, 48'h000A35000001, source MAC, transmitted MSB first.
- ETHERTYPE, 16'h88B5, EtherType field.
- FRAME_LEN, 64, frame bytes excluding FCS. Legal range 60..9000.
- IFG, 12, idle cycles after the last byte before the next frame may start. Legal range 1..255.

Ports:
- rx_clk  in  1  byte clock; all logic runs on it.
- reset  in  1  asynchronous, active-high.
- start  in  1  request one frame; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last byte is accepted.
- seq  out  32  sequence number of the frame currently or last sent.
- tx_ts  out  32  timestamp latched at the first-byte ack.
- mac_tx_data  out  8  transmit byte.
- mac_tx_dvld  out  1  byte valid.
- mac_tx_ack  in  1  MAC accepted the first byte.
- mac_tx_underrun  out  1  held 0.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, seq=0, tx_ts=0, mac_tx_data=0, mac_tx_dvld=0, mac_tx_underrun=0. Also ts_cnt=0, byte_cnt=0, state=IDLE.
- ts_cnt is a free-running 32-bit counter: +1 every cycle, wraps 32'hFFFFFFFF->0.
- Frame byte map (index = byte_cnt, 14 bits):
  - 0-5: DST_MAC.
  - 6-11: SRC_MAC.
  - 12-13: ETHERTYPE.
  - 14-17: seq, big-endian.
  - 18-21: tx_ts, big-endian.
  - 22..FRAME_LEN-1: pad byte = byte_cnt[7:0].
- States: IDLE, WAIT_ACK, DATA, GAP.
- IDLE:
  - On start=1, the next cycle enters WAIT_ACK with mac_tx_dvld=1 and mac_tx_data=DST_MAC[47:40].
  - Otherwise mac_tx_dvld=0.
- WAIT_ACK:
  - Holds byte 0 and dvld until mac_tx_ack=1. Ack is legal in the first WAIT_ACK cycle.
  - In the ack cycle: tx_ts<=ts_cnt, byte_cnt<=1, go to DATA.
  - The next cycle presents byte 1.
- DATA:
  - One byte per cycle with dvld=1. The MAC applies no back-pressure after ack.
  - The cycle presenting byte FRAME_LEN-1 is the last DATA cycle.
  - The next cycle: dvld=0, done=1 for one cycle, seq<=seq+1 (wraps to 0), go to GAP.
- GAP:
  - Counts IFG cycles with dvld=0, then returns to IDLE.
  - The earliest next-frame dvld is IFG+1 cycles after the last-byte cycle.
- start while busy=1 is ignored and not queued.
- A start held high produces back-to-back frames separated by exactly IFG+1 dvld-low cycles.
- mac_tx_ack outside WAIT_ACK is ignored.
- Reset asserted mid-frame:
  - dvld drops asynchronously and the state machine returns to IDLE.
  - seq, ts_cnt and tx_ts clear.
  - No done pulse.
- mac_tx_data is 0 whenever dvld=0.

Test Plan:
- Single frame, default params, ack 3 cycles after dvld rises:
  - byte 0 (0xFF) is held for 4 cycles.
  - Then bytes 1-63 are contiguous, with bytes 12-13 = 0x88,0xB5 and bytes 14-17 = 0x00000000.
  - Bytes 18-21 equal ts_cnt at the ack cycle; pad byte 22 = 0x16 and byte 63 = 0x3F.
  - done pulses once; seq becomes 1.
- Ack in the first WAIT_ACK cycle:
  - Byte 0 is presented for exactly 1 cycle.
  - Total dvld-high cycles = 64.
- start held high for 3 frames, ack immediate:
  - Frames carry seq 0,1,2.
  - Exactly 13 dvld-low cycles between frames.
  - 3 done pulses; tx_ts values differ by 64+13=77.
- start pulsed at DATA byte 10 and again during GAP:
  - Both pulses are ignored.
  - busy stays 1 until IDLE; only one frame is sent.
- Reset asserted at DATA byte 30:
  - dvld=0 immediately; seq=0, busy=0, no done.
  - The next start produces a complete frame with seq=0.
- FRAME_LEN=60, IFG=1:
  - 60-byte frame; pad bytes run 0x16..0x3B.
  - With start held, exactly 2 idle cycles between frames.
